// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci sequencer: FSM states, widths and the queued result entry.
package fib_pkg;

    localparam int FIB_N_W   = 6;
    localparam int FIB_VAL_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_PUSH
    } fib_state_t;

    typedef struct packed {
        logic [FIB_N_W-1:0]   n;
        logic [FIB_VAL_W-1:0] value;
        logic                 err;
    } fib_entry_t;

    localparam int ENTRY_W = $bits(fib_entry_t);

endpackage

// File: rtl/fib_result_fifo.sv
// First-word-fall-through result queue; head reads as zero while empty.
module fib_result_fifo
    import fib_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [ENTRY_W-1:0]       head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    // A pop on a full queue frees the slot the same-cycle push writes into.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    // NOTE: use non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign valid = (count != '0);
    assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fib_seq_ctrl.sv
// Request sequencer for a downstream Fibonacci core: one job in flight, results queued FWFT.
// Defining FIB_SEQ_TIMEOUT_EN adds a RUN-state abort after TIMEOUT_CYCLES cycles.
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 80
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [FIB_N_W-1:0]   req_n,
    output logic                 core_rst,
    output logic [FIB_N_W-1:0]   core_n,
    input  logic                 core_ready,
    input  logic [FIB_VAL_W-1:0] core_value,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [FIB_VAL_W-1:0] rsp_value,
    output logic [FIB_N_W-1:0]   rsp_n,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    fib_state_t           state;
    fib_state_t           state_nxt;
    logic [FIB_VAL_W-1:0] cap_value;
    logic [FIB_VAL_W-1:0] cap_value_nxt;
    logic                 cap_err;
    logic                 cap_err_nxt;
    logic [CNT_W-1:0]     fifo_count;
    logic                 req_fire;
    logic                 push;
    fib_entry_t           push_entry;
    fib_entry_t           head_entry;
    logic [ENTRY_W-1:0]   head_bits;

`ifdef FIB_SEQ_TIMEOUT_EN
    localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT_CYCLES - 1);

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_cnt_nxt;
`endif

    // Acceptance looks only at registered count, so a same-cycle pop cannot reopen it early.
    assign req_ready = !rst && (state == S_IDLE) && (fifo_count < FULL_CNT);
    assign req_fire  = req_valid && req_ready;
    assign core_rst  = rst || (state == S_CLEAR);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            core_n    <= '0;
            cap_value <= '0;
            cap_err   <= 1'b0;
`ifdef FIB_SEQ_TIMEOUT_EN
            run_cnt   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cap_value <= cap_value_nxt;
            cap_err   <= cap_err_nxt;
`ifdef FIB_SEQ_TIMEOUT_EN
            run_cnt   <= run_cnt_nxt;
`endif
            if (req_fire) core_n <= req_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt     = state;
        cap_value_nxt = cap_value;
        cap_err_nxt   = cap_err;
        push          = 1'b0;
`ifdef FIB_SEQ_TIMEOUT_EN
        run_cnt_nxt   = run_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (req_fire) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                cap_value_nxt = '0;
                cap_err_nxt   = 1'b0;
`ifdef FIB_SEQ_TIMEOUT_EN
                run_cnt_nxt   = '0;
`endif
                state_nxt     = S_RUN;
            end
            S_RUN: begin
                if (core_ready) begin
                    cap_value_nxt = core_value;
                    state_nxt     = S_PUSH;
`ifdef FIB_SEQ_TIMEOUT_EN
                end else if (run_cnt == RUN_LAST) begin
                    cap_value_nxt = '0;
                    cap_err_nxt   = 1'b1;
                    state_nxt     = S_PUSH;
                end else begin
                    run_cnt_nxt   = run_cnt + 1'b1;
`endif
                end
            end
            S_PUSH: begin
                push      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign push_entry = '{n: core_n, value: cap_value, err: cap_err};

    fib_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_entry),
        .pop      (rsp_ready),
        .valid    (rsp_valid),
        .head     (head_bits),
        .count    (fifo_count)
    );

    assign head_entry = head_bits;
    assign rsp_value  = head_entry.value;
    assign rsp_n      = head_entry.n;

`ifdef FIB_SEQ_TIMEOUT_EN
    assign rsp_err = head_entry.err;
`else
    logic head_err_unused;
    assign head_err_unused = head_entry.err;
    assign rsp_err         = 1'b0;
`endif

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl with a behavioural Fibonacci core; covers both FIB_SEQ_TIMEOUT_EN builds.
module tb_fib_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_n;
    logic        core_rst;
    logic [5:0]  core_n;
    logic        core_ready;
    logic [31:0] core_value;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_value;
    logic [5:0]  rsp_n;
    logic        rsp_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    fib_seq_ctrl #(
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(80)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_n     (req_n),
        .core_rst  (core_rst),
        .core_n    (core_n),
        .core_ready(core_ready),
        .core_value(core_value),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_value (rsp_value),
        .rsp_n     (rsp_n),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Behavioural core: after core_rst drops, result appears core_lat cycles later and stays up.
    int core_lat  = 1;
    bit core_hold = 1'b0;
    int core_cyc;

    function automatic logic [31:0] fib(input logic [5:0] n);
        logic [31:0] a = 0;
        logic [31:0] b = 1;
        logic [31:0] t;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(posedge clk) begin
        if (core_rst) begin
            core_cyc   <= 0;
            core_ready <= 1'b0;
            core_value <= '0;
        end else begin
            core_cyc <= core_cyc + 1;
            if (!core_hold && (core_cyc + 1 >= core_lat)) begin
                core_ready <= 1'b1;
                core_value <= fib(core_n);
            end
        end
    end

    int          pulses = 0;
    logic [5:0]  pop_n[$];
    logic [31:0] pop_v[$];

    always @(posedge clk) begin
        if (!rst && core_rst) pulses <= pulses + 1;
        if (!rst && rsp_valid && rsp_ready) begin
            pop_n.push_back(rsp_n);
            pop_v.push_back(rsp_value);
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic [5:0] n);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_n     = n;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("send_accepted", ok, 1);
    endtask

    task automatic wait_rsp(input int limit, output int k);
        k = 0;
        while (!rsp_valid && k < limit) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic pop_one();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          p0;
        int          base;
        logic [5:0]  exp_n[4];
        logic [31:0] exp_v[4];

        rst       = 1'b1;
        req_valid = 1'b0;
        req_n     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_value", rsp_value, 0);
        check("rst_rsp_n", rsp_n, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_core_n", core_n, 0);
        check("rst_busy", busy, 0);
        check("rst_core_rst", core_rst, 1);

        rst = 1'b0;
        @(negedge clk);
        check("idle_core_rst", core_rst, 0);
        check("idle_req_ready", req_ready, 1);

        // Single request n=10
        p0 = pulses;
        send(6'd10);
        check("clear_busy", busy, 1);
        check("clear_core_rst", core_rst, 1);
        check("clear_core_n", core_n, 10);
        wait_rsp(20, k);
        check("n10_latency", k, 4);
        check("n10_value", rsp_value, 55);
        check("n10_n", rsp_n, 10);
        check("n10_err", rsp_err, 0);
        check("n10_pulses", pulses - p0, 1);
        check("n10_busy_done", busy, 0);
        pop_one();
        check("n10_popped", rsp_valid, 0);

        // Back-to-back with the consumer always ready
        base      = pop_n.size();
        rsp_ready = 1'b1;
        send(6'd1);
        send(6'd2);
        send(6'd3);
        repeat (10) @(negedge clk);
        rsp_ready = 1'b0;
        exp_n = '{6'd1, 6'd2, 6'd3, 6'd0};
        exp_v = '{32'd1, 32'd1, 32'd2, 32'd0};
        check("b2b_count", pop_n.size() - base, 3);
        if (pop_n.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b2b_n%0d", i), pop_n[base+i], exp_n[i]);
                check($sformatf("b2b_v%0d", i), pop_v[base+i], exp_v[i]);
            end
        end

        // Fill the queue, then a fifth request must be held off
        send(6'd4);
        send(6'd5);
        send(6'd6);
        send(6'd7);
        repeat (8) @(negedge clk);
        check("full_req_ready", req_ready, 0);
        check("full_head_n", rsp_n, 4);
        req_valid = 1'b1;
        req_n     = 6'd8;
        @(negedge clk);
        req_n = 6'd9;
        @(negedge clk);
        check("full_core_n_held", core_n, 7);
        check("full_still_blocked", req_ready, 0);
        rsp_ready = 1'b1;
        req_n     = 6'd8;
        check("pop_cycle_req_ready", req_ready, 0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("reopen_req_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("fifth_core_n", core_n, 8);

        // Pop lands on the push cycle of the fifth job
        repeat (3) @(negedge clk);
        check("coinc_pre_head_n", rsp_n, 5);
        pop_one();
        check("coinc_req_ready", req_ready, 1);
        check("coinc_head_n", rsp_n, 6);
        send(6'd9);
        repeat (8) @(negedge clk);
        check("refill_req_ready", req_ready, 0);
        exp_n = '{6'd6, 6'd7, 6'd8, 6'd9};
        exp_v = '{32'd8, 32'd13, 32'd21, 32'd34};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid%0d", i), rsp_valid, 1);
            check($sformatf("drain_n%0d", i), rsp_n, exp_n[i]);
            check($sformatf("drain_v%0d", i), rsp_value, exp_v[i]);
            pop_one();
        end
        check("drain_empty", rsp_valid, 0);
        pop_one();
        check("empty_pop_ignored", rsp_valid, 0);

`ifdef FIB_SEQ_TIMEOUT_EN
        core_hold = 1'b1;
        send(6'd7);
        wait_rsp(120, k);
        check("to_latency", k, 82);
        check("to_err", rsp_err, 1);
        check("to_value", rsp_value, 0);
        check("to_n", rsp_n, 7);
        pop_one();
        core_hold = 1'b0;
`else
        core_hold = 1'b1;
        send(6'd7);
        repeat (120) @(negedge clk);
        check("nto_busy", busy, 1);
        check("nto_rsp_valid", rsp_valid, 0);
        check("nto_rsp_err", rsp_err, 0);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        core_hold = 1'b0;
        @(negedge clk);
`endif

        // Reset while RUN with two entries queued
        send(6'd1);
        send(6'd2);
        repeat (6) @(negedge clk);
        core_hold = 1'b1;
        send(6'd3);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_rsp_valid", rsp_valid, 1);
        check("pre_rst_head_n", rsp_n, 1);
        rst = 1'b1;
        check("rst_comb_req_ready", req_ready, 0);
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_core_rst", core_rst, 1);
        check("mid_rst_core_n", core_n, 0);
        check("mid_rst_rsp_value", rsp_value, 0);
        rst       = 1'b0;
        core_hold = 1'b0;
        @(negedge clk);
        check("post_rst_core_rst", core_rst, 0);
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_rsp_valid", rsp_valid, 0);

        send(6'd10);
        wait_rsp(20, k);
        check("post_rst_latency", k, 4);
        check("post_rst_value", rsp_value, 55);
        pop_one();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fib_seq_ctrl.md
FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, result-FIFO entries (power of two, min 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 80, max RUN cycles before abort.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted when both high.
REQ-007 req_n  input  6  requested Fibonacci index.
REQ-008 core_rst  output  1  reset to downstream Fibonacci core.
REQ-009 core_n  output  6  index driven to core.
REQ-010 core_ready  input  1  core result valid.
REQ-011 core_value  input  32  core result.
REQ-012 rsp_valid  output  1  FIFO head valid.
REQ-013 rsp_ready  input  1  consumer pops head when both high.
REQ-014 rsp_value  output  32  result of head entry.
REQ-015 rsp_n  output  6  index of head entry.
REQ-016 rsp_err  output  1  head entry aborted by timeout.
REQ-017 busy  output  1  high when state is not IDLE.

Function
REQ-018 SHALL implement FSM IDLE, CLEAR, RUN, PUSH; one request in flight at a time.
REQ-019 IDLE: req_ready = (FIFO count < FIFO_DEPTH); on handshake latch req_n into core_n, go CLEAR.
REQ-020 CLEAR: core_rst=1 for exactly one cycle; next state RUN; core_ready ignored in CLEAR.
REQ-021 RUN: core_rst=0; first cycle core_ready=1 captures core_value, goes PUSH.
REQ-022 PUSH: write {core_n, captured value, err} to FIFO in one cycle, return IDLE.
REQ-023 Request-to-push latency SHALL be 2 + (RUN cycles until core_ready) + 1 cycles.
REQ-024 core_rst SHALL equal rst OR (state==CLEAR); core_n holds its value outside IDLE.
REQ-025 FIFO SHALL be first-word-fall-through; rsp_* reflect head while rsp_valid=1.
REQ-026 Simultaneous push and pop SHALL leave count unchanged, both take effect.
REQ-027 Pop with rsp_valid=0 SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-028 Full FIFO SHALL hold req_ready=0; a pop in the same cycle does not raise req_ready until next cycle.
REQ-029 core_n SHALL be unchanged while req_ready=0 regardless of req_n.

Reset
REQ-030 On rst: state IDLE, FIFO empty, rsp_valid=0, rsp_value=0, rsp_n=0, rsp_err=0, core_n=0, busy=0, core_rst=1.
REQ-031 rst mid-operation SHALL discard the in-flight request and all FIFO contents.
REQ-032 req_ready SHALL be 0 during rst.

Configuration
REQ-033 Macro FIB_SEQ_TIMEOUT_EN: defined -> RUN counter; reaching TIMEOUT_CYCLES without core_ready goes PUSH with value=0, err=1.
REQ-034 Undefined -> no counter, RUN waits indefinitely, rsp_err tied 0.

Structure
REQ-035 Shared package fib_pkg SHALL hold state enum, FIB_N_W=6, FIB_VAL_W=32, and the result-entry struct {n, value, err}.
REQ-036 FIFO SHALL be sub-module fib_result_fifo (parameterised depth, count output).

Verification
REQ-037 Model core (n=10 -> 55): req_n=10 -> one core_rst pulse, rsp_valid=1 with rsp_value=55, rsp_n=10, rsp_err=0.
REQ-038 Back-to-back requests n=1,2,3 with rsp_ready=1 -> responses in order, values 1,1,2.
REQ-039 rsp_ready=0, 5 requests, depth 4 -> 4 accepted, req_ready=0, one pop reopens acceptance next cycle.
REQ-040 Timeout build, core_ready held 0 -> after 80 RUN cycles entry with rsp_err=1, rsp_value=0.
REQ-041 rst asserted in RUN with 2 entries queued -> next cycle IDLE, rsp_valid=0, core_rst=1.
REQ-042 Full FIFO with simultaneous push/pop cycle -> count stays 4, order preserved.
